// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and mode constants.
package addsub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_NEG  = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit ripple-carry adder slice, shared by the add and negate phases.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             co
);

  logic c;

  always_comb begin
    c   = cin;
    s_d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i] = a_d[i] ^ b_d[i] ^ c;
      c      = (a_d[i] & b_d[i]) | (a_d[i] & c) | (b_d[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial unsigned adder/subtractor; differences are returned as sign-magnitude.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ctr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             sign
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   r_q, r_d;

  logic [DIGIT-1:0]   dig_a, dig_b, dig_s;
  logic               dig_co;
  logic               last;
  logic [WIDTH-1:0]   r_shift;

  // In NEG the raw result rotates through r_q: low digit read inverted, new digit enters on top.
  assign dig_a   = (state_q == ST_NEG) ? ~r_q[DIGIT-1:0] : a_q[DIGIT-1:0];
  assign dig_b   = (state_q == ST_NEG) ? '0 :
                   ((mode_q == MODE_SUB) ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0]);
  assign last    = (cnt_q == CNT_W'(N - 1));
  assign r_shift = (r_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d (dig_a),
    .b_d (dig_b),
    .cin (carry_q),
    .s_d (dig_s),
    .co  (dig_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    sign_d  = sign_q;
    s_d     = s_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADD;
          a_d     = a;
          b_d     = b;
          mode_d  = ctr;
          carry_d = ctr;
          cnt_d   = '0;
        end
      end
      ST_ADD: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        r_d     = r_shift;
        carry_d = dig_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          cnt_d = '0;
          // A missing final carry on subtraction means A < B: negate the raw result.
          if (mode_q == MODE_ADD || dig_co) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            s_d     = r_shift;
            cout_d  = dig_co;
            sign_d  = 1'b0;
          end else begin
            state_d = ST_NEG;
            carry_d = 1'b1;
          end
        end
      end
      ST_NEG: begin
        r_d     = r_shift;
        carry_d = dig_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          carry_d = 1'b0;
          done_d  = 1'b1;
          s_d     = r_shift;
          cout_d  = 1'b0;
          sign_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      sign_q  <= 1'b0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      sign_q  <= sign_d;
      s_q     <= s_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    r_q <= r_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign sign = sign_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: DIGIT=2 and DIGIT=8 instances at WIDTH=8.
module tb_addsub_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ctr = 1'b0;
  logic       start2 = 1'b0, start8 = 1'b0;

  logic       busy2, done2, cout2, sign2;
  logic [7:0] s2;
  logic       busy8, done8, cout8, sign8;
  logic [7:0] s8;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         e0 = 0;
  logic [7:0] prev_s [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .ctr(ctr), .a(a), .b(b),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2), .sign(sign2)
  );

  addsub_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ctr(ctr), .a(a), .b(b),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .sign(sign8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input int sel, output logic bz, output logic dn,
                      output logic co, output logic sg, output logic [7:0] sv);
    if (sel == 1) begin
      bz = busy8; dn = done8; co = cout8; sg = sign8; sv = s8;
    end else begin
      bz = busy2; dn = done2; co = cout2; sg = sign2; sv = s2;
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge E0.
  task automatic launch(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a = av; b = bv; ctr = cv;
    if (sel == 1) start8 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    start2 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int lat);
    logic bz, dn, co, sg;
    logic [7:0] sv;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      peek(sel, bz, dn, co, sg, sv);
      if (dn === 1'b1) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic check_result(input int sel, input string tag, input logic [7:0] es,
                              input logic ec, input logic esg, input int elat, input int lat);
    logic bz, dn, co, sg;
    logic [7:0] sv;
    peek(sel, bz, dn, co, sg, sv);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_s"}, sv, es);
    chk({tag, "_cout"}, co, ec);
    chk({tag, "_sign"}, sg, esg);
    chk({tag, "_busy_done"}, bz, 1'b0);
    prev_s[sel] = es;
  endtask

  task automatic run_op(input int sel, input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec, input logic esg,
                        input int elat);
    logic bz, dn, co, sg;
    logic [7:0] sv;
    int lat;
    launch(sel, av, bv, cv);
    peek(sel, bz, dn, co, sg, sv);
    chk({tag, "_busy"}, bz, 1'b1);
    chk({tag, "_hold"}, sv, prev_s[sel]);
    wait_done(sel, lat);
    check_result(sel, tag, es, ec, esg, elat, lat);
    @(negedge clk);
    peek(sel, bz, dn, co, sg, sv);
    chk({tag, "_pulse"}, dn, 1'b0);
  endtask

  int lat;
  int ndone;

  initial begin
    prev_s[0] = 8'h00;
    prev_s[1] = 8'h00;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); ctr = 1'($urandom);
      start2 = 1'($urandom); start8 = 1'($urandom);
    end
    chk("rst_busy", busy2, 1'b0);
    chk("rst_done", done2, 1'b0);
    chk("rst_s", s2, 8'h00);
    chk("rst_cout", cout2, 1'b0);
    chk("rst_sign", sign2, 1'b0);
    chk("rst_busy8", busy8, 1'b0);
    start2 = 1'b0; start8 = 1'b0;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done2 || done8) ndone++;
    end
    chk("idle_no_done", ndone, 0);

    run_op(0, "add_carry",  8'hFF, 8'h07, 1'b1 ^ 1'b1, 8'h06, 1'b1, 1'b0, 4);
    run_op(0, "sub_borrow", 8'h00, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1, 8);
    run_op(0, "add_small",  8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 4);
    run_op(0, "sub_pos",    8'h50, 8'h30, 1'b1, 8'h20, 1'b1, 1'b0, 4);
    run_op(0, "sub_neg",    8'h30, 8'h50, 1'b1, 8'h20, 1'b0, 1'b1, 8);
    run_op(0, "sub_eq",     8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 4);

    // Start pulses and operand changes while busy are ignored
    launch(0, 8'h50, 8'h30, 1'b1);
    start2 = 1'b1; a = 8'hFF; b = 8'h01; ctr = 1'b0;
    @(negedge clk);
    a = 8'h11;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(0, lat);
    check_result(0, "midop", 8'h20, 1'b1, 1'b0, 4, lat);
    @(negedge clk);
    chk("midop_pulse", done2, 1'b0);

    // Back-to-back: next start issued in the done cycle
    launch(0, 8'h12, 8'h34, 1'b0);
    wait_done(0, lat);
    check_result(0, "b2b_first", 8'h46, 1'b0, 1'b0, 4, lat);
    launch(0, 8'h0F, 8'h01, 1'b0);
    chk("b2b_busy", busy2, 1'b1);
    wait_done(0, lat);
    check_result(0, "b2b_second", 8'h10, 1'b0, 1'b0, 4, lat);
    @(negedge clk);

    run_op(1, "w_add", 8'hFF, 8'h07, 1'b0, 8'h06, 1'b1, 1'b0, 1);
    run_op(1, "w_sub", 8'h00, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1, 2);

    // Abort at E2
    launch(0, 8'hFF, 8'h07, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_s", s2, 8'h00);
    chk("abort_busy", busy2, 1'b0);
    chk("abort_done", done2, 1'b0);
    chk("abort_sign8", sign8, 1'b0);
    chk("abort_s8", s8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    prev_s[0] = 8'h00;
    prev_s[1] = 8'h00;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done2 || done8) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run_op(0, "recover", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial adder/subtractor, successor to the fixed 4-bit combinational add/sub unit.
- Takes WIDTH-bit unsigned operands and a mode bit, processes DIGIT bits per clock under a start/busy/done handshake.
- Returns a WIDTH-bit result with carry-out; subtraction results are returned in sign-magnitude form.
- Serves as the area-lean arithmetic engine for datapaths that can tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; WIDTH >= 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH.
- Derived N = WIDTH/DIGIT: digit cycles per pass.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while idle.
- ctr  in  1  mode: 0 = A+B, 1 = A-B.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; results valid in that cycle.
- s  out  WIDTH  sum, or magnitude of the difference.
- cout  out  1  add: carry-out; sub: 1 = no borrow (A >= B).
- sign  out  1  add: always 0; sub: 1 when A < B.

## Operation
- FSM states:
  - IDLE: accepts start.
  - ADD: N cycles computing A + (ctr ? ~B : B) + ctr, LSB digit first, carry held in a flop between digits.
  - NEG: N cycles computing ~R + 1 on the raw result R.
- Transitions:
  - IDLE -> ADD on start. a, b and ctr are captured into internal registers; later input changes are ignored.
  - ADD -> IDLE after digit N-1 when ctr=0, or when ctr=1 and the final carry is 1.
  - ADD -> NEG when ctr=1 and the final carry is 0 (borrow).
  - NEG -> IDLE after digit N-1.
- Output update on completion only:
  - s, cout and sign load together on the completing edge, then hold until the next completion.
  - No intermediate values are ever visible on the outputs.
- Subtraction results:
  - Borrow case: sign=1, cout=0, s=B-A.
  - A == B: s=0, sign=0, cout=1. Zero is never negative.
- start while busy=1 is ignored, with no queuing.
- Width rules:
  - Internal digit counter is clog2(N)+1 bits.
  - Carry flop is 1 bit.
  - All arithmetic is modulo 2^WIDTH plus carry.

## Timing
- Reset values (rst_n low, asynchronous): state IDLE, busy=0, done=0, s=0, cout=0, sign=0. Counter and carry cleared.
- Edge numbering: start is sampled high at edge E0.
  - busy=1 from E0.
  - Digits are processed at edges E1..EN.
- Latency, no NEG: the completing edge is EN. done=1 and busy=0 for the cycle after EN.
- Latency, with NEG: NEG digits are processed at edges EN+1..E2N, and completion is at E2N.
- done lasts exactly one cycle. That done cycle is an IDLE cycle, so start is accepted in it, giving back-to-back operation.
- Reset mid-operation: the operation is aborted, no done is produced, and outputs go to their reset values.
- DIGIT=WIDTH (N=1): add latency is 1 cycle after start; borrow latency is 2 cycles.

## Structure
- Shared package addsub_pkg:
  - FSM state encoding (IDLE, ADD, NEG) as localparams/typedef.
  - Mode constants MODE_ADD=0 and MODE_SUB=1.
- Sub-module addsub_digit: DIGIT-bit ripple adder (a_d, b_d, cin -> s_d, co), instantiated once and shared by the ADD and NEG phases through operand muxing.
- Top level holds:
  - the FSM;
  - operand shift registers, shifted right by DIGIT per cycle;
  - the result shift register;
  - the carry flop and the counter.

## Test plan
Parameters are WIDTH=8, DIGIT=2 (N=4) unless stated.
- Reset: hold rst_n low with random inputs -> busy=0, done=0, s=0x00, cout=0, sign=0. Release, then idle with start=0 -> no done.
- Add with carry: A=0xFF, B=0x07, ctr=0 -> done 4 cycles after start, s=0x06, cout=1, sign=0.
- Sub with borrow: A=0x00, B=0x01, ctr=1 -> done 8 cycles after start, s=0x01, cout=0, sign=1.
- Sub without borrow and equal operands:
  - A=0x50, B=0x30 -> s=0x20, cout=1, sign=0, latency 4.
  - A=B=0x80 -> s=0x00, cout=1, sign=0.
- Handshake:
  - start pulsed while busy, and a/b changed mid-operation -> ignored; the result matches the captured operands.
  - start in the done cycle -> the second operation completes 4 cycles later.
- Abort and extreme DIGIT:
  - rst_n dropped at E2 -> outputs reset and no done pulse.
  - Rerun the add and borrow cases with DIGIT=8 -> latencies 1 and 2.
